// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch.
// Provides the control-state encoding and the digit geometry used by the
// top level and the per-digit counters.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter with rollover at MAX.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-low reset
//   clr    - synchronous clear to 0 (wins over en)
//   en     - count enable
//   q      - current digit value
//   carry  - combinational: en and q == MAX (next digit should advance)
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] MAX_Q = DIGIT_W'(MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == MAX_Q) ? '0 : q + 1'b1;
    end
  end

  assign carry = en && (q == MAX_Q);

endmodule

// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch core (SS.hh).
// Ports:
//   clk      - system clock
//   reset    - synchronous active-low reset
//   tick     - one-cycle count enable from the clock-enable stage
//   btn_run  - debounced run/stop level
//   btn_clr  - debounced clear level
//   btn_lap  - debounced lap/split level
//   digits   - BCD display: [3:0] hundredths .. [15:12] seconds tens
//   running  - high in RUN or LAP
//   lapped   - high in LAP (display frozen on lap-hold value)
//   wrap     - one-cycle pulse when the count rolls over to 00.00
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned D3_MAX = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_run,
  input  logic        btn_clr,
  input  logic        btn_lap,
  output logic [15:0] digits,
  output logic        running,
  output logic        lapped,
  output logic        wrap
);

  state_t      state, state_nxt;
  logic        run_h, clr_h, lap_h;
  logic        run_raw, clr_raw, lap_raw;
  logic        run_p, clr_p, lap_p;
  logic        capture, clr_cnt, cnt_en;
  logic [15:0] count, lap_hold;
  logic [DIGIT_W-1:0] q0, q1, q2, q3;
  logic        c0, c1, c2, c3;

  // History loads even during reset so a button held through reset
  // release does not register as a press.
  always_ff @(posedge clk) begin
    run_h <= btn_run;
    clr_h <= btn_clr;
    lap_h <= btn_lap;
  end

  assign run_raw = btn_run & ~run_h;
  assign clr_raw = btn_clr & ~clr_h;
  assign lap_raw = btn_lap & ~lap_h;

  // Only the highest-priority press acts: clr > run > lap.
  assign clr_p = clr_raw;
  assign run_p = run_raw & ~clr_raw;
  assign lap_p = lap_raw & ~clr_raw & ~run_raw;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_p) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (clr_p)      state_nxt = ST_IDLE;
        else if (run_p) state_nxt = ST_PAUSE;
        else if (lap_p) begin
          state_nxt = ST_LAP;
          capture   = 1'b1;
        end
      end
      ST_LAP: begin
        if (clr_p)      state_nxt = ST_IDLE;
        else if (run_p) state_nxt = ST_PAUSE;
        else if (lap_p) state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (clr_p)      state_nxt = ST_IDLE;
        else if (run_p) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counting follows the registered state, so a press in the same cycle as
  // a tick sees the pre-transition state. Clearing overrides the tick.
  assign cnt_en  = tick && ((state == ST_RUN) || (state == ST_LAP));
  assign clr_cnt = (state_nxt == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  bcd_digit_cnt #(.MAX(9)) u_d0 (
    .clk(clk), .reset(reset), .clr(clr_cnt), .en(cnt_en), .q(q0), .carry(c0)
  );
  bcd_digit_cnt #(.MAX(9)) u_d1 (
    .clk(clk), .reset(reset), .clr(clr_cnt), .en(c0), .q(q1), .carry(c1)
  );
  bcd_digit_cnt #(.MAX(9)) u_d2 (
    .clk(clk), .reset(reset), .clr(clr_cnt), .en(c1), .q(q2), .carry(c2)
  );
  bcd_digit_cnt #(.MAX(D3_MAX)) u_d3 (
    .clk(clk), .reset(reset), .clr(clr_cnt), .en(c2), .q(q3), .carry(c3)
  );

  assign count = {q3, q2, q1, q0};

  always_ff @(posedge clk) begin
    if (!reset) begin
      lap_hold <= '0;
      wrap     <= 1'b0;
    end else begin
      if (clr_cnt)      lap_hold <= '0;
      else if (capture) lap_hold <= count;
      wrap <= c3 & ~clr_cnt;
    end
  end

  // Outputs are selected purely from registered state.
  assign digits  = (state == ST_LAP) ? lap_hold : count;
  assign running = (state == ST_RUN) || (state == ST_LAP);
  assign lapped  = (state == ST_LAP);

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

  localparam int LIMIT = 6000;  // (5+1)*1000 centiseconds
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0, btn_run = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
  logic [15:0] digits, digits2;
  logic        running, lapped, wrap, running2, lapped2, wrap2;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  int m_st, m_cnt, m_hold;
  bit m_wrap, p_run, p_clr, p_lap;

  stopwatch_bcd dut (
    .clk(clk), .reset(rst_n), .tick(tick), .btn_run(btn_run),
    .btn_clr(btn_clr), .btn_lap(btn_lap), .digits(digits),
    .running(running), .lapped(lapped), .wrap(wrap)
  );

  stopwatch_bcd #(.D3_MAX(2)) dut2 (
    .clk(clk), .reset(rst_n), .tick(tick), .btn_run(btn_run),
    .btn_clr(btn_clr), .btn_lap(btn_lap), .digits(digits2),
    .running(running2), .lapped(lapped2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r, c, l, t;
    logic [15:0] d;
    bit run, lap, w;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [15:0] to_bcd(input int n);
    logic [3:0] a, b, c, d;
    a = 4'(n / 1000);
    b = 4'((n / 100) % 10);
    c = 4'((n / 10) % 10);
    d = 4'(n % 10);
    return {a, b, c, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit c, input bit l, input bit t);
    bit pr, pc, pl, w;
    int nst, ncnt;
    pr = r && !p_run;
    pc = c && !p_clr;
    pl = l && !p_lap;
    ncnt = m_cnt;
    w = 0;
    if (t && (m_st == M_RUN || m_st == M_LAP)) begin
      ncnt = m_cnt + 1;
      if (ncnt == LIMIT) begin
        ncnt = 0;
        w = 1;
      end
    end
    nst = m_st;
    if (pc) nst = M_IDLE;
    else if (pr) nst = (m_st == M_RUN || m_st == M_LAP) ? M_PAUSE : M_RUN;
    else if (pl) begin
      if (m_st == M_RUN) begin
        nst = M_LAP;
        m_hold = m_cnt;
      end else if (m_st == M_LAP) nst = M_RUN;
    end
    if (nst == M_IDLE) begin
      ncnt = 0;
      m_hold = 0;
      w = 0;
    end
    m_st = nst;
    m_cnt = ncnt;
    m_wrap = w;
    p_run = r;
    p_clr = c;
    p_lap = l;
  endtask

  task automatic apply(input bit r, input bit c, input bit l, input bit t);
    btn_run = r; btn_clr = c; btn_lap = l; tick = t;
    @(posedge clk); #1;
    model_step(r, c, l, t);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      apply(0, 0, 0, 1);
      for (int j = 1; j < gap; j++) apply(0, 0, 0, 0);
    end
  endtask

  task automatic do_reset(input bit r, input bit c, input bit l);
    rst_n = 1'b0;
    btn_run = r; btn_clr = c; btn_lap = l; tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_st = M_IDLE; m_cnt = 0; m_hold = 0; m_wrap = 0;
    p_run = r; p_clr = c; p_lap = l;
    rst_n = 1'b1;
    tick = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_digits"}, 32'(digits), 32'(to_bcd(m_st == M_LAP ? m_hold : m_cnt)));
    chk({tag, "_running"}, 32'(running), 32'(m_st == M_RUN || m_st == M_LAP));
    chk({tag, "_lapped"}, 32'(lapped), 32'(m_st == M_LAP));
    chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 16'h0000, 1, 0, 0};  // IDLE run -> RUN
    tbl[1]  = '{0, 0, 0, 1, 16'h0001, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 16'h0002, 1, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 16'h0002, 1, 1, 0};  // RUN lap -> LAP
    tbl[4]  = '{0, 0, 0, 1, 16'h0002, 1, 1, 0};  // frozen display
    tbl[5]  = '{0, 0, 0, 1, 16'h0002, 1, 1, 0};
    tbl[6]  = '{0, 0, 1, 0, 16'h0004, 1, 0, 0};  // LAP lap -> RUN, live
    tbl[7]  = '{1, 0, 0, 1, 16'h0005, 0, 0, 0};  // RUN run+tick -> PAUSE, inc
    tbl[8]  = '{0, 0, 0, 1, 16'h0005, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 1, 16'h0005, 1, 0, 0};  // PAUSE run+tick: no inc
    tbl[10] = '{0, 0, 1, 0, 16'h0005, 1, 1, 0};
    tbl[11] = '{1, 0, 0, 0, 16'h0005, 0, 0, 0};  // LAP run -> PAUSE
    tbl[12] = '{0, 1, 1, 0, 16'h0000, 0, 0, 0};  // clr beats lap
    tbl[13] = '{1, 0, 0, 1, 16'h0000, 1, 0, 0};  // IDLE tick ignored
    tbl[14] = '{0, 0, 0, 1, 16'h0001, 1, 0, 0};
    tbl[15] = '{1, 1, 1, 1, 16'h0000, 0, 0, 0};  // clr beats run/lap/tick
    tbl[16] = '{0, 1, 0, 0, 16'h0000, 0, 0, 0};  // held clr, no press
    tbl[17] = '{0, 0, 1, 0, 16'h0000, 0, 0, 0};  // IDLE ignores lap

    // reset with all buttons held, then release while still held
    do_reset(1, 1, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_digits", 32'(digits), 32'h0000);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_lapped", 32'(lapped), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;
    apply(1, 1, 1, 1);
    apply(1, 1, 1, 0);
    chk("held_digits", 32'(digits), 32'h0000);
    chk("held_running", 32'(running), 32'd0);

    // table-driven vectors
    do_reset(0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].t);
      chk($sformatf("tbl%0d_digits", i), 32'(digits), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_running", i), 32'(running), 32'(tbl[i].run));
      chk($sformatf("tbl%0d_lapped", i), 32'(lapped), 32'(tbl[i].lap));
      chk($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].w));
    end

    // 123 ticks, then pause
    do_reset(0, 0, 0);
    apply(1, 0, 0, 0);
    ticks(123, 10);
    chk("cnt123_digits", 32'(digits), 32'h0123);
    chk("cnt123_running", 32'(running), 32'd1);
    apply(1, 0, 0, 0);
    ticks(20, 10);
    chk("pause_digits", 32'(digits), 32'h0123);
    chk("pause_running", 32'(running), 32'd0);

    // full rollover on both digit-3 limits
    do_reset(0, 0, 0);
    apply(1, 0, 0, 0);
    ticks(5999, 1);
    chk("pre_wrap_digits", 32'(digits), 32'h5999);
    chk("pre_wrap_digits2", 32'(digits2), 32'h2999);
    chk("pre_wrap_wrap", 32'(wrap), 32'd0);
    apply(0, 0, 0, 1);
    chk("wrap_digits", 32'(digits), 32'h0000);
    chk("wrap_pulse", 32'(wrap), 32'd1);
    chk("wrap_digits2", 32'(digits2), 32'h0000);
    chk("wrap_pulse2", 32'(wrap2), 32'd1);
    apply(0, 0, 0, 0);
    chk("wrap_end", 32'(wrap), 32'd0);
    chk("wrap_end2", 32'(wrap2), 32'd0);
    chk("wrap_running", 32'(running), 32'd1);

    // clear coincident with a rollover tick: no wrap
    ticks(5999, 1);
    chk("pre_clr_digits", 32'(digits), 32'h5999);
    apply(0, 1, 0, 1);
    chk("clr_tick_digits", 32'(digits), 32'h0000);
    chk("clr_tick_wrap", 32'(wrap), 32'd0);
    chk("clr_tick_wrap2", 32'(wrap2), 32'd0);
    chk("clr_tick_running", 32'(running), 32'd0);

    // lap hold at 0x0042 over 50 ticks
    do_reset(0, 0, 0);
    apply(1, 0, 0, 0);
    ticks(42, 10);
    apply(0, 0, 1, 0);
    chk("lap_digits", 32'(digits), 32'h0042);
    chk("lap_lapped", 32'(lapped), 32'd1);
    ticks(25, 10);
    chk("lap_mid_digits", 32'(digits), 32'h0042);
    ticks(25, 10);
    chk("lap_end_digits", 32'(digits), 32'h0042);
    chk("lap_end_lapped", 32'(lapped), 32'd1);
    apply(0, 0, 1, 0);
    chk("unlap_digits", 32'(digits), 32'h0092);
    chk("unlap_lapped", 32'(lapped), 32'd0);

    // clr+run+tick in RUN
    do_reset(0, 0, 0);
    apply(1, 0, 0, 0);
    ticks(3, 10);
    apply(1, 1, 0, 1);
    chk("clrrun_digits", 32'(digits), 32'h0000);
    chk("clrrun_running", 32'(running), 32'd0);
    chk("clrrun_wrap", 32'(wrap), 32'd0);

    // run press + tick at 0x0009
    do_reset(0, 0, 0);
    apply(1, 0, 0, 0);
    ticks(9, 10);
    apply(1, 0, 0, 1);
    chk("runtick_digits", 32'(digits), 32'h0010);
    chk("runtick_running", 32'(running), 32'd0);
    apply(0, 0, 0, 1);
    chk("runtick_paused", 32'(digits), 32'h0010);

    // reset mid-operation with a tick
    ticks(2, 1);
    apply(1, 0, 0, 0);
    ticks(5, 1);
    rst_n = 1'b0; tick = 1'b1;
    @(posedge clk); #1;
    chk("midrst_digits", 32'(digits), 32'h0000);
    chk("midrst_running", 32'(running), 32'd0);

    // randomized against the reference model
    do_reset(0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      chk_model("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Four-digit BCD stopwatch core (SS.hh format) sitting directly downstream of the clock-enable stage. It consumes that stage's single-cycle `tick` pulse and advances a BCD count on each tick. It interprets run/clear/lap button levels through internal rising-edge detection and a four-state control FSM. It presents the digits to the seven-segment display driver.

## Interface
Parameters:
- `D3_MAX`, default 5: maximum value of digit 3 (seconds tens); the count wraps after D3_MAX,9,9,9.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-low reset; asserted when 0, sampled on `clk` rising edge.
- `tick` input 1: one-cycle count enable from the clock-enable stage.
- `btn_run` input 1: debounced run/stop button level.
- `btn_clr` input 1: debounced clear button level.
- `btn_lap` input 1: debounced lap/split button level.
- `digits` output 16: BCD display value; [3:0] hundredths, [7:4] tenths, [11:8] seconds units, [15:12] seconds tens.
- `running` output 1: high in RUN or LAP.
- `lapped` output 1: high in LAP (display frozen).
- `wrap` output 1: one-cycle pulse when the count rolls over to 00.00.

## Operation
- Edge detect: a press is `btn_x` = 1 while its history register = 0. History registers load the live button value every cycle, including during reset, so a button held through reset release produces no press.
- Press priority in one cycle: clr > run > lap. Only the highest-priority press acts; the others are dropped.
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: run → RUN. clr and lap are ignored.
  - RUN: run → PAUSE; lap → LAP and capture count into the lap-hold register; clr → IDLE.
  - LAP: lap → RUN (display goes live); run → PAUSE (display goes live, showing the stopped count); clr → IDLE.
  - PAUSE: run → RUN; clr → IDLE; lap is ignored.
- Count: increments on `tick` when the current (registered) state is RUN or LAP.
  - Digits 0–2 roll over at 9 → 0 with carry.
  - Digit 3 rolls over at D3_MAX → 0.
  - A full rollover (D3_MAX,9,9,9 → 0,0,0,0) pulses `wrap`.
- Clear: entering IDLE zeroes the count and the lap-hold register on the same edge. Clear beats a coincident tick: the count goes to 0, not 1, and there is no `wrap`.
- Display: `digits` = count outside LAP, lap-hold register in LAP. The count keeps advancing underneath while in LAP.
- Press and tick in the same cycle: the tick uses the pre-transition state.
  - RUN + run press + tick: the count increments and the state goes to PAUSE.
  - PAUSE + run press + tick: no increment.

## Timing
- Reset values: state IDLE, count 0, lap-hold 0, `digits` 0x0000, `running` 0, `lapped` 0, `wrap` 0.
- Press latency: button rises in cycle N, press is detected in cycle N (combinational against history), state and outputs change at the edge ending cycle N, and are visible in cycle N+1.
- Tick latency: a tick in cycle N updates the count and `digits` at the same edge; the new value is visible in N+1.
- `wrap` is high for exactly the cycle in which `digits` (live) first shows 0x0000 after rollover. In LAP it still pulses even though `digits` is frozen.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-operation: every register returns to its reset value on the next edge with `reset` = 0, regardless of state or tick.

## Structure
- Shared package `stopwatch_pkg`:
  - state encoding constants (IDLE=0, RUN=1, PAUSE=2, LAP=3);
  - BCD digit width (4);
  - digit count (4).
- Sub-module `bcd_digit_cnt`:
  - parameter `MAX`;
  - inputs: `clk`, `reset`, `clr`, `en`;
  - outputs: `q[3:0]`, `carry` (combinational: `en` and q==MAX).
- Instantiate four `bcd_digit_cnt` in a carry chain. The top level holds the FSM, edge detect, lap-hold and output registers.

## Test plan
Bench drives `tick` every 10 cycles to mirror the upstream stage.
- Reset with all buttons high, then release → no state change; `digits` 0x0000, `running` 0.
- Press run, apply 123 ticks → `digits` 0x0123, `running` 1. Press run → PAUSE; 20 further ticks leave 0x0123.
- From count 0x5999 in RUN, one tick → `digits` 0x0000 and `wrap` high for one cycle. With D3_MAX=2, 0x2999 → 0x0000.
- In RUN at 0x0042, press lap → `digits` holds 0x0042 and `lapped` 1 for 50 ticks. Press lap → `digits` shows 0x0092.
- clr and run pressed together with a coincident tick in RUN → state IDLE, `digits` 0x0000, no `wrap`.
- RUN, then run press and tick in the same cycle at 0x0009 → `digits` 0x0010, state PAUSE, `running` 0 next cycle.
